// File: rtl/imm_decode_pkg.sv
// Shared constants for the immediate-decode stage: format codes and RV base opcodes.
package imm_decode_pkg;

    localparam int FMT_W = 3;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Only CSR-immediate forms (csrrwi/csrrsi/csrrci) carry a zimm field.
    function automatic logic is_csr_imm(input logic [2:0] funct3);
        return funct3[2] && (funct3[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream handshake bundle of the immediate-decode stage.
interface imm_decode_stage_if
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [FMT_W-1:0]  out_fmt;
    logic [XLEN-1:0]   out_pc;
    logic              out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_skid_buf.sv
// Valid/ready buffer: SKID!=0 gives a 2-entry skid buffer with registered in_ready,
// SKID==0 a single output register. Outputs always come straight from flops.
module imm_skid_buf #(
    parameter int W    = 8,
    parameter int SKID = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         push_s;
    logic         pop_s;
    logic         out_valid_r;
    logic [W-1:0] out_data_r;

    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid_r && out_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    generate
        if (SKID != 0) begin : g_skid
            logic         skid_valid_r;
            logic         in_ready_r;
            logic [W-1:0] skid_data_r;

            assign in_ready = in_ready_r;

            // Head register plus one skid slot; in_ready drops once both are full.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_r  <= 1'b0;
                    out_data_r   <= '0;
                    skid_valid_r <= 1'b0;
                    skid_data_r  <= '0;
                    in_ready_r   <= 1'b1;
                end else if (!out_valid_r) begin
                    if (push_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= in_data;
                    end
                end else if (pop_s) begin
                    // A full skid slot blocks push, so refill comes from skid first.
                    if (skid_valid_r) begin
                        out_data_r   <= skid_data_r;
                        skid_valid_r <= 1'b0;
                        in_ready_r   <= 1'b1;
                    end else if (push_s) begin
                        out_data_r <= in_data;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end else if (push_s) begin
                    skid_valid_r <= 1'b1;
                    skid_data_r  <= in_data;
                    in_ready_r   <= 1'b0;
                end
            end
        end else begin : g_single
            assign in_ready = !out_valid_r || out_ready;

            // Single register: load on push, drain on pop without replacement.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_r <= 1'b0;
                    out_data_r  <= '0;
                end else if (push_s) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= in_data;
                end else if (pop_s) begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: classifies the RV opcode, builds the XLEN immediate and
// buffers the result. Define IMM_DECODE_ZICSR_EN to decode CSR zimm (format Z).
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input logic                clk,
    input logic                rst,
    imm_decode_stage_if.slave  bus
);
    localparam int W = 2 * XLEN + FMT_W + 1;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    logic [31:0]      instr_s;
    logic [6:0]       opcode_s;
    logic [FMT_W-1:0] fmt_s;
    logic             illegal_s;
    logic [31:0]      imm32_s;
    logic [XLEN-1:0]  imm_s;
    logic [W-1:0]     in_data_s;
    logic [W-1:0]     out_data_s;

    assign instr_s  = bus.in_instr;
    assign opcode_s = instr_s[6:0];

    // Opcode classification; illegal entries report format NONE.
    always_comb begin
        fmt_s     = FMT_NONE;
        illegal_s = 1'b0;
        if (instr_s[1:0] != 2'b11) begin
            illegal_s = 1'b1;
        end else begin
            case (opcode_s)
                OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt_s = FMT_I;
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) begin
                        fmt_s = FMT_I;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end
                OPC_STORE:             fmt_s = FMT_S;
                OPC_BRANCH:            fmt_s = FMT_B;
                OPC_LUI, OPC_AUIPC:    fmt_s = FMT_U;
                OPC_JAL:               fmt_s = FMT_J;
                OPC_OP, OPC_MISC_MEM:  fmt_s = FMT_NONE;
                OPC_OP_32: begin
                    if (XLEN == 64) begin
                        fmt_s = FMT_NONE;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end
                OPC_SYSTEM: begin
`ifdef IMM_DECODE_ZICSR_EN
                    if (is_csr_imm(instr_s[14:12])) begin
                        fmt_s = FMT_Z;
                    end else begin
                        fmt_s = FMT_NONE;
                    end
`else
                    fmt_s = FMT_NONE;
`endif
                end
                default: illegal_s = 1'b1;
            endcase
        end
    end

    // Immediate bit assembly; NONE and illegal fall through to zero.
    always_comb begin
        imm32_s = 32'd0;
        case (fmt_s)
            FMT_I: imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
            FMT_S: imm32_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
            FMT_B: imm32_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7],
                              instr_s[30:25], instr_s[11:8], 1'b0};
            FMT_U: imm32_s = {instr_s[31:12], 12'd0};
            FMT_J: imm32_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12],
                              instr_s[20], instr_s[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    // Widen to XLEN: zimm is zero-extended, everything else sign-extended from bit 31.
    always_comb begin
        imm_s = '0;
        if (fmt_s == FMT_Z) begin
            imm_s[4:0] = instr_s[19:15];
        end else begin
            imm_s        = {XLEN{imm32_s[31]}};
            imm_s[31:0]  = imm32_s;
        end
    end

    assign in_data_s = {imm_s, fmt_s, bus.in_pc, illegal_s};

    imm_skid_buf #(
        .W    (W),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data_s),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data_s)
    );

    assign {bus.out_imm, bus.out_fmt, bus.out_pc, bus.out_illegal} = out_data_s;

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; the module SHALL accept only 32 or 64 (any other value is an elaboration error).
REQ-002 Parameter SKID, default 1; 1 selects a 2-entry skid buffer for full throughput, 0 selects a single output register.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  upstream instruction valid.
REQ-006 in_ready  out  1  stage can accept an instruction this cycle.
REQ-007 in_instr  in  32  raw instruction word.
REQ-008 in_pc  in  XLEN  instruction address, passed through unchanged.
REQ-009 out_valid  out  1  output entry valid.
REQ-010 out_ready  in  1  downstream accepts the output entry.
REQ-011 out_imm  out  XLEN  extended immediate.
REQ-012 out_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
REQ-013 out_pc  out  XLEN  pc of the output entry.
REQ-014 out_illegal  out  1  opcode not recognised for this configuration.

Function
REQ-015 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-016 Latency: an instruction accepted at edge N SHALL be presented with out_valid=1 from edge N+1; there is no combinational path from in_* to out_*.
REQ-017 Decode: I for OP-IMM, LOAD, JALR (and OP-IMM-32 when XLEN=64); S for STORE; B for BRANCH; U for LUI, AUIPC; J for JAL; NONE for OP, MISC-MEM, SYSTEM (and OP-32 when XLEN=64).
REQ-018 I/S/B/J immediates SHALL be bit-assembled per the RISC-V base ISA and sign-extended from instr[31] to XLEN; B and J SHALL have bit 0 = 0.
REQ-019 U immediate SHALL be {instr[31:12], 12'b0} sign-extended from bit 31 to XLEN.
REQ-020 NONE and illegal entries SHALL carry out_imm = 0.
REQ-021 out_illegal SHALL be 1 with out_fmt = NONE when instr[1:0] != 2'b11, when the opcode is outside REQ-017, or when OP-IMM-32/OP-32 appears with XLEN=32.
REQ-022 SKID=1: in_ready SHALL equal "fewer than 2 entries held" (registered, independent of out_ready); with continuous out_ready=1 the stage SHALL sustain one transfer per cycle.
REQ-023 SKID=0: in_ready SHALL equal !out_valid || out_ready.
REQ-024 Ordering: entries SHALL leave in acceptance order; simultaneous in/out transfers SHALL neither drop nor duplicate an entry.
REQ-025 While out_valid=1 and out_ready=0, all out_* SHALL be held stable.

Reset
REQ-026 rst=1 at an edge SHALL empty all entries: out_valid=0, in_ready=1 after that edge; out_imm, out_pc=0, out_fmt=NONE, out_illegal=0.
REQ-027 Reset mid-operation SHALL discard held entries without presenting them; inputs offered during rst=1 SHALL not be accepted.

Configuration
REQ-028 Macro IMM_DECODE_ZICSR_EN defined: SYSTEM opcode with funct3 in {101,110,111} SHALL yield fmt Z, out_imm = instr[19:15] zero-extended to XLEN; other SYSTEM funct3 stay NONE.
REQ-029 Macro undefined: all SYSTEM instructions SHALL yield fmt NONE, out_imm 0; code Z never appears.

Structure
REQ-030 Package imm_decode_pkg SHALL hold the 3-bit format codes and the 7-bit opcode constants.
REQ-031 Handshake buffering SHALL be the sub-module imm_skid_buf (parameterised payload width and SKID); decode stays combinational before it.

Verification
REQ-032 XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
REQ-033 XLEN=64, in_instr=0x80000037 (lui) -> out_imm=0xFFFFFFFF80000000, fmt 4; XLEN=32 with 0x0000001B -> out_illegal=1, out_imm=0.
REQ-034 in_instr=0xFE000EE3 (beq -4), in_pc=0x100 -> out_imm=0xFFFFFFFC, fmt 3, out_pc=0x100.
REQ-035 SKID=1, out_ready=0 for 3 cycles while offering A,B,C -> A,B accepted, in_ready=0 on 3rd cycle, C held upstream; out_ready=1 -> A,B,C out in order, no gaps.
REQ-036 Two entries held, rst=1 for one cycle -> out_valid=0 and in_ready=1 next cycle; neither held entry ever appears.
REQ-037 With IMM_DECODE_ZICSR_EN, 0x3050D073 (csrrwi) -> fmt 6, out_imm=0x1; without macro -> fmt 0, out_imm=0.
